// File: rtl/dsp_arb_pkg.sv
// ============================================================================
// Module   : dsp_arb_pkg
// Brief    : Shared widths, tag type and round-robin pick for dsp_round_arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_arb_pkg;

  localparam int AW_DEF   = 24;
  localparam int BW_DEF   = 16;
  localparam int LAT_DEF  = 4;
  localparam int NREQ_MAX = 8;
  // ID field sized for the largest supported requester count
  localparam int IDW      = 3;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  // First asserted request at or above ptr, wrapping at nreq
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                             input logic [IDW-1:0]      ptr,
                                             input int                  nreq);
    logic [IDW-1:0] gnt;
    logic           found;
    int             idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      if (i < nreq) begin
        idx = int'(ptr) + i;
        if (idx >= nreq) idx = idx - nreq;
        if (!found && req[idx[IDW-1:0]]) begin
          gnt   = idx[IDW-1:0];
          found = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_round_arbiter_if.sv
// ============================================================================
// Module   : dsp_round_arbiter_if
// Brief    : Requester and response handshake bundle of the DSP arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dsp_round_arbiter_if
  import dsp_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF,
  parameter int BW   = BW_DEF
);
  localparam int c_ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_a;
  logic [NREQ*BW-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [AW-1:0]      rsp_data;
  logic [c_ID_W-1:0]  rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

`default_nettype wire

// File: rtl/dsp_arb_fifo.sv
// ============================================================================
// Module   : dsp_arb_fifo
// Brief    : Circular result FIFO with push/pop, full/empty and occupancy
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int c_CW = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] din,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic      [c_CW-1:0]  count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr;
  logic [c_PW-1:0]  r_rd;
  logic [c_CW-1:0]  r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == c_CW'(DEPTH));
  assign count = r_count;
  assign dout  = r_mem[r_rd];

  // A pop in the same cycle frees the slot a full-FIFO push lands in
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= (r_wr == c_PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_do_pop)  r_rd <= (r_rd == c_PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

`default_nettype wire

// File: rtl/dsp_round_arbiter.sv
// ============================================================================
// Module   : dsp_round_arbiter
// Brief    : Round-robin share of one fixed-latency DSP multiplier, credit-
//            protected result FIFO toward a single valid/ready response port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_round_arbiter
  import dsp_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int AW         = AW_DEF,
  parameter int BW         = BW_DEF,
  parameter int LAT        = LAT_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  dsp_round_arbiter_if.slave bus,
  output logic      [AW-1:0] dsp_a,
  output logic      [BW-1:0] dsp_b,
  input  wire logic [AW-1:0] dsp_z,
  output logic               busy
);

  localparam int c_ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_CW   = $clog2(FIFO_DEPTH + 1);
  localparam int c_LW   = $clog2(LAT + 1);

  logic [IDW-1:0]        r_ptr;
  logic [c_CW-1:0]       r_credits;
  tag_t                  r_tag [LAT];
  logic [IDW-1:0]        w_gnt;
  logic                  w_grant_ok;
  logic                  w_issue;
  logic                  w_pop;
  logic [c_LW-1:0]       w_inflight;
  logic [AW+c_ID_W-1:0]  w_head;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [c_CW-1:0]       w_fifo_count;

  assign w_gnt      = rr_pick(NREQ_MAX'(bus.req_valid), r_ptr, NREQ);
  assign w_grant_ok = (|bus.req_valid) && (r_credits != '0);
  assign bus.req_ready = w_grant_ok ? (NREQ'(1) << w_gnt) : '0;
  assign w_issue    = |(bus.req_valid & bus.req_ready);
  assign w_pop      = bus.rsp_valid & bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_a     <= '0;
      dsp_b     <= '0;
      r_ptr     <= '0;
      r_credits <= c_CW'(FIFO_DEPTH);
    end else begin
      if (w_issue) begin
        dsp_a <= bus.req_a[int'(w_gnt)*AW +: AW];
        dsp_b <= bus.req_b[int'(w_gnt)*BW +: BW];
        r_ptr <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
      end
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Tag pipe mirrors the multiplier latency and never stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{vld: w_issue, id: w_gnt};
      for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) w_inflight = w_inflight + c_LW'(r_tag[i].vld);
  end

  if (c_ID_W < IDW) begin : g_id_trim
    logic w_unused_id;
    assign w_unused_id = ^r_tag[LAT-1].id[IDW-1:c_ID_W];
  end

  dsp_arb_fifo #(
    .WIDTH (AW + c_ID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_tag[LAT-1].vld),
    .din   ({dsp_z, r_tag[LAT-1].id[c_ID_W-1:0]}),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign bus.rsp_valid = !w_fifo_empty;
  assign bus.rsp_data  = w_head[c_ID_W +: AW];
  assign bus.rsp_id    = w_head[c_ID_W-1:0];
  assign busy          = (w_inflight != '0) || bus.rsp_valid;

  a_credit_balance: assert property (@(posedge clk) disable iff (!rst_n)
    int'(r_credits) + int'(w_inflight) + int'(w_fifo_count) == FIFO_DEPTH);
  a_push_room: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_tag[LAT-1].vld && w_fifo_full && !w_pop));

endmodule

`default_nettype wire
